part2_sequencer: RTL and testbench

- Microprogram controller for the part2 datapath: input buffer (EA), ALU plus accumulator (EB), output buffer (EC).
- Fetches 8-bit instructions from an external asynchronous program ROM.
- Drives D0, SLCT, EA, EB and EC to run each instruction.
- Captures CRRY/ZRO for conditional jumps; sits between the ROM and part2 in the lab top level.

---
 rtl/part2_pkg.sv | 44 ++++
 rtl/part2_sequencer.sv | 114 +++++++++++
 tb/tb_part2_sequencer.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/part2_pkg.sv
// Shared constants for the part2 microprogram sequencer:
// ALU select codes, opcodes and FSM state encoding.
package part2_pkg;

  localparam logic [2:0] SL_PASS_A = 3'b000;
  localparam logic [2:0] SL_SUB    = 3'b001;
  localparam logic [2:0] SL_PASS_B = 3'b010;
  localparam logic [2:0] SL_ADD    = 3'b011;
  localparam logic [2:0] SL_NAND   = 3'b100;

  localparam logic [3:0] OP_NOP   = 4'h0;
  localparam logic [3:0] OP_LDI   = 4'h1;
  localparam logic [3:0] OP_ADDI  = 4'h2;
  localparam logic [3:0] OP_SUBI  = 4'h3;
  localparam logic [3:0] OP_NANDI = 4'h4;
  localparam logic [3:0] OP_OUT   = 4'h5;
  localparam logic [3:0] OP_JMP   = 4'h6;
  localparam logic [3:0] OP_JZ    = 4'h7;
  localparam logic [3:0] OP_JC    = 4'h8;
  localparam logic [3:0] OP_HALT  = 4'hF;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LOAD,
    S_ACC,
    S_OUT,
    S_HALT
  } state_e;

  function automatic logic [2:0] alu_sel(input logic [3:0] op);
    logic [2:0] s;
    s = SL_PASS_A;
    case (op)
      OP_LDI:   s = SL_PASS_B;
      OP_ADDI:  s = SL_ADD;
      OP_SUBI:  s = SL_SUB;
      OP_NANDI: s = SL_NAND;
      default:  s = SL_PASS_A;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/part2_sequencer.sv
// Microprogram controller for the part2 datapath.
// Fetches from an async ROM and drives D0/SLCT/EA/EB/EC.
module part2_sequencer
  import part2_pkg::*;
#(
  parameter int PC_W   = 4,
  parameter int DATA_W = 4
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              START,
  input  logic [7:0]        INSTR,
  input  logic              CRRY,
  input  logic              ZRO,
  output logic [PC_W-1:0]   PC,
  output logic [DATA_W-1:0] D0,
  output logic [2:0]        SLCT,
  output logic              EA,
  output logic              EB,
  output logic              EC,
  output logic              BUSY,
  output logic              HALTED
);

  state_e     state;
  logic [3:0] ir;
  logic       cf;
  logic       zf;

  logic [3:0]      op;
  logic [PC_W-1:0] tgt;
  logic [PC_W-1:0] pc_inc;

  assign op     = INSTR[7:4];
  assign tgt    = PC_W'(INSTR[3:0]);
  assign pc_inc = PC + PC_W'(1);

  // Outputs are set on entry to the state that owns them,
  // so every enable is a clean one-cycle registered pulse.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state  <= S_IDLE;
      PC     <= '0;
      D0     <= '0;
      SLCT   <= SL_PASS_A;
      EA     <= 1'b0;
      EB     <= 1'b0;
      EC     <= 1'b0;
      BUSY   <= 1'b0;
      HALTED <= 1'b0;
      ir     <= OP_NOP;
      cf     <= 1'b0;
      zf     <= 1'b0;
    end else begin
      EA <= 1'b0;
      EB <= 1'b0;
      EC <= 1'b0;
      unique case (state)
        S_IDLE, S_HALT: begin
          if (START) begin
            PC     <= '0;
            state  <= S_FETCH;
            BUSY   <= 1'b1;
            HALTED <= 1'b0;
          end
        end
        S_FETCH: begin
          ir <= op;
          case (op)
            OP_LDI, OP_ADDI, OP_SUBI, OP_NANDI: begin
              state <= S_LOAD;
              D0    <= DATA_W'(INSTR[3:0]);
              EA    <= 1'b1;
            end
            OP_OUT: begin
              state <= S_OUT;
              SLCT  <= SL_PASS_A;
              EC    <= 1'b1;
            end
            OP_JMP: PC <= tgt;
            OP_JZ:  PC <= zf ? tgt : pc_inc;
            OP_JC:  PC <= cf ? tgt : pc_inc;
            OP_HALT: begin
              state  <= S_HALT;
              BUSY   <= 1'b0;
              HALTED <= 1'b1;
            end
            default: PC <= pc_inc;
          endcase
        end
        S_LOAD: begin
          state <= S_ACC;
          SLCT  <= alu_sel(ir);
          EB    <= 1'b1;
        end
        S_ACC: begin
          cf    <= CRRY;
          zf    <= ZRO;
          PC    <= pc_inc;
          state <= S_FETCH;
        end
        S_OUT: begin
          PC    <= pc_inc;
          state <= S_FETCH;
        end
        default: begin
          state <= S_IDLE;
          BUSY  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_part2_sequencer.sv
// Bench for part2_sequencer: ROM, datapath stand-in and an
// instruction-level reference that predicts every busy cycle.
module tb_part2_sequencer;

  logic       CLK = 1'b0;
  logic       RST;
  logic       START;
  logic [7:0] INSTR;
  logic       CRRY;
  logic       ZRO;
  logic [3:0] PC;
  logic [3:0] D0;
  logic [2:0] SLCT;
  logic       EA, EB, EC, BUSY, HALTED;

  int errors = 0;
  int checks = 0;

  always #5 CLK = ~CLK;

  part2_sequencer #(.PC_W(4), .DATA_W(4)) dut (
    .CLK(CLK), .RST(RST), .START(START), .INSTR(INSTR),
    .CRRY(CRRY), .ZRO(ZRO), .PC(PC), .D0(D0), .SLCT(SLCT),
    .EA(EA), .EB(EB), .EC(EC), .BUSY(BUSY), .HALTED(HALTED)
  );

  logic [7:0] rom [16];
  assign INSTR = rom[PC];

  // part2 datapath stand-in: B = input buffer, A = accumulator
  logic [3:0] dp_a, dp_b, dp_out;
  logic [4:0] alu_w;
  always_comb begin
    alu_w = 5'd0;
    case (SLCT)
      3'b000:  alu_w = {1'b0, dp_a};
      3'b001:  alu_w = {1'b0, dp_a} - {1'b0, dp_b};
      3'b010:  alu_w = {1'b0, dp_b};
      3'b011:  alu_w = {1'b0, dp_a} + {1'b0, dp_b};
      3'b100:  alu_w = {1'b0, ~(dp_a & dp_b)};
      default: alu_w = 5'd0;
    endcase
  end
  assign CRRY = alu_w[4];
  assign ZRO  = (alu_w[3:0] == 4'd0);

  always @(posedge CLK or posedge RST) begin
    if (RST) begin
      dp_a <= '0; dp_b <= '0; dp_out <= '0;
    end else begin
      if (EA) dp_b <= D0;
      if (EB) dp_a <= alu_w[3:0];
      if (EC) dp_out <= alu_w[3:0];
    end
  end

  task automatic chk(input string n, input logic [31:0] a,
                     input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, a, e);
    end
  endtask

  typedef struct {
    logic [3:0] pc;
    logic       ea, eb, ec;
    logic [3:0] d0;
    logic [2:0] slct;
    logic       busy, halted;
  } exp_t;

  exp_t exp_q[$];
  int   pc_log[$];
  int   busy_log[$];
  bit   armed = 0;
  int   lim;

  // architectural state of the reference: accumulator and flags
  logic [3:0] m_a;
  logic       m_cf, m_zf;

  task automatic add(input logic [3:0] pc, input logic [2:0] en,
                     input logic [3:0] d0, input logic [2:0] sl,
                     input logic bz, input logic hl);
    exp_t e;
    if (exp_q.size() >= lim) return;
    e.pc = pc; e.ea = en[2]; e.eb = en[1]; e.ec = en[0];
    e.d0 = d0; e.slct = sl; e.busy = bz; e.halted = hl;
    exp_q.push_back(e);
  endtask

  task automatic build(input int max);
    logic [3:0] pc, op, imm;
    logic [4:0] r;
    logic [2:0] sl;
    bit done;
    lim = max; pc = 4'd0; done = 0;
    while (!done && exp_q.size() < max) begin
      op = rom[pc][7:4];
      imm = rom[pc][3:0];
      add(pc, 3'b000, 4'd0, 3'd0, 1'b1, 1'b0);
      if (op == 4'hF) begin
        add(pc, 3'b000, 4'd0, 3'd0, 1'b0, 1'b1);
        done = 1;
      end else if (op >= 4'h1 && op <= 4'h4) begin
        case (op)
          4'h1: begin r = {1'b0, imm}; sl = 3'b010; end
          4'h2: begin r = {1'b0, m_a} + {1'b0, imm}; sl = 3'b011; end
          4'h3: begin r = {1'b0, m_a} - {1'b0, imm}; sl = 3'b001; end
          default: begin r = {1'b0, ~(m_a & imm)}; sl = 3'b100; end
        endcase
        add(pc, 3'b100, imm, 3'd0, 1'b1, 1'b0);
        add(pc, 3'b010, 4'd0, sl, 1'b1, 1'b0);
        m_a = r[3:0]; m_cf = r[4]; m_zf = (r[3:0] == 4'd0);
        pc = pc + 4'd1;
      end else if (op == 4'h5) begin
        add(pc, 3'b001, 4'd0, 3'b000, 1'b1, 1'b0);
        pc = pc + 4'd1;
      end else if (op == 4'h6) pc = imm;
      else if (op == 4'h7) pc = m_zf ? imm : pc + 4'd1;
      else if (op == 4'h8) pc = m_cf ? imm : pc + 4'd1;
      else pc = pc + 4'd1;
    end
  endtask

  always @(negedge CLK) begin : cmp
    exp_t e;
    if (armed && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      pc_log.push_back(int'(PC));
      busy_log.push_back(int'(BUSY));
      chk("pc", PC, e.pc);
      chk("enables", {EA, EB, EC}, {e.ea, e.eb, e.ec});
      chk("busy", BUSY, e.busy);
      chk("halted", HALTED, e.halted);
      if (e.ea) chk("d0", D0, e.d0);
      if (e.eb || e.ec) chk("slct", SLCT, e.slct);
    end
  end

  task automatic fill(input logic [7:0] v);
    for (int i = 0; i < 16; i++) rom[i] = v;
  endtask

  task automatic run(input int max, input int glitch);
    int g;
    exp_q.delete(); pc_log.delete(); busy_log.delete();
    build(max);
    @(posedge CLK); #1 START = 1'b1;
    @(posedge CLK); #1 START = 1'b0;
    armed = 1;
    g = 0;
    while (exp_q.size() > 0 && g < max + 10) begin
      @(negedge CLK); #1;
      START = (g == glitch);
      g++;
    end
    START = 1'b0;
    chk("drain_timeout", exp_q.size(), 0);
    armed = 0;
  endtask

  function automatic int busy_cnt();
    int n = 0;
    foreach (busy_log[i]) n += busy_log[i];
    return n;
  endfunction

  function automatic int log_at(input int i);
    if (i < pc_log.size()) return pc_log[i];
    return -1;
  endfunction

  initial begin
    int g;
    RST = 1'b1; START = 1'b0;
    m_a = 0; m_cf = 0; m_zf = 0;
    fill(8'hF0);
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_pc", PC, 0);
    chk("rst_busy", BUSY, 0);
    chk("rst_halted", HALTED, 0);
    chk("rst_en", {EA, EB, EC}, 0);
    chk("rst_d0_slct", {D0, SLCT}, 0);
    RST = 1'b0;
    repeat (10) begin
      @(negedge CLK);
      chk("idle_en", {EA, EB, EC, BUSY}, 0);
    end

    // LDI A, ADDI 3, OUT, HALT
    fill(8'hF0);
    rom[0] = 8'h1A; rom[1] = 8'h23; rom[2] = 8'h50;
    run(20, -1);
    chk("a_len", pc_log.size(), 10);
    chk("a_halt_pc", log_at(9), 3);
    chk("a_busy_cycles", busy_cnt(), 9);
    chk("a_model_acc", m_a, 4'hD);
    chk("a_out", dp_out, 4'hD);

    // JZ taken after LDI 0 (START from HALT)
    fill(8'hF0);
    rom[0] = 8'h10; rom[1] = 8'h74; rom[2] = 8'h50; rom[4] = 8'h50;
    run(20, -1);
    chk("jz_pc1", log_at(3), 1);
    chk("jz_pc4", log_at(4), 4);
    chk("jz_len", pc_log.size(), 8);
    chk("jz_out", dp_out, 0);

    // ZF retained across restart
    fill(8'hF0);
    rom[0] = 8'h74;
    run(10, -1);
    chk("zf_kept", log_at(1), 4);

    // JZ falls through after nonzero LDI
    fill(8'hF0);
    rom[0] = 8'h15; rom[1] = 8'h74; rom[2] = 8'h50;
    run(20, -1);
    chk("jz_fall", log_at(4), 2);
    chk("jz_fall_out", dp_out, 5);

    // SUBI without borrow, JC not taken, opcode B as NOP
    fill(8'hF0);
    rom[0] = 8'h15; rom[1] = 8'h33; rom[2] = 8'h86; rom[3] = 8'hB0;
    run(20, -1);
    chk("jc_fall", log_at(7), 3);
    chk("nop_b", log_at(8), 4);
    chk("jc_len", pc_log.size(), 10);
    chk("sub_acc", dp_a, 2);

    // ADDI overflow sets CF, JC taken
    fill(8'hF0);
    rom[0] = 8'h1F; rom[1] = 8'h21; rom[2] = 8'h86;
    run(20, -1);
    chk("jc_taken", log_at(7), 6);

    // all-NOP wrap, START while busy ignored
    fill(8'h00);
    run(40, 5);
    chk("wrap_15", log_at(15), 15);
    chk("wrap_0", log_at(16), 0);
    chk("wrap_busy", busy_cnt(), 40);
    chk("wrap_halted", HALTED, 0);

    // async reset in the middle of ACC
    @(negedge CLK); RST = 1'b1;
    m_a = 0; m_cf = 0; m_zf = 0;
    @(negedge CLK); RST = 1'b0;
    fill(8'hF0);
    rom[0] = 8'h1A;
    @(posedge CLK); #1 START = 1'b1;
    @(posedge CLK); #1 START = 1'b0;
    g = 0;
    while (!EB && g < 10) begin
      @(negedge CLK); g++;
    end
    chk("eb_seen", EB, 1);
    #2 RST = 1'b1;
    #1;
    chk("rst_async_eb", EB, 0);
    chk("rst_async_pc", PC, 0);
    chk("rst_async_busy", BUSY, 0);
    @(negedge CLK); RST = 1'b0;
    repeat (3) begin
      @(negedge CLK);
      chk("post_rst_idle", {EA, EB, EC, BUSY, HALTED}, 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
